unary_bin_decoder: RTL and testbench

- Window-based unary-to-binary decoder, the receiving end of the Sobol-RNG/comparator unary bitstream path.
- Counts the ones in an incoming unary bitstream over a window of 2^BITWIDTH enabled cycles.
- At the end of each window it latches the count as a BITWIDTH-bit binary value and pulses a valid strobe.
- Sits at the output of the unary datapath, for example after the butterfly stages, and feeds binary consumers and benches.

---
 rtl/unary_bin_decoder.sv | 92 +++++++++
 tb/tb_unary_bin_decoder.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/unary_bin_decoder.sv
// rtl/unary_bin_decoder.sv - windowed unary-to-binary decoder (ones count over 2^BITWIDTH enabled samples)
module unary_bin_decoder #(
    parameter int BITWIDTH = 8
) (
    input  logic                iClk,
    input  logic                iRstN,
    input  logic                iEn,
    input  logic                iClr,
    input  logic                iUnary,
    output logic [BITWIDTH-1:0] oBin,
    output logic                oValid,
    output logic                oSat,
    output logic                oBusy
);

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

    // Last window index; also the saturated output value (all ones).
    localparam logic [BITWIDTH-1:0] WIN_LAST = '1;
    localparam logic [BITWIDTH-1:0] WIN_INC  = BITWIDTH'(1);
    // A window of all ones counts to exactly 2^BITWIDTH.
    localparam logic [BITWIDTH:0]   FULL     = {1'b1, {BITWIDTH{1'b0}}};

    state_t              state_q, state_d;
    logic [BITWIDTH-1:0] win_cnt_q, win_cnt_d;
    logic [BITWIDTH:0]   one_cnt_q, one_cnt_d;
    logic [BITWIDTH-1:0] bin_q, bin_d;
    logic                valid_q, valid_d;
    logic                sat_q, sat_d;
    logic                busy_q, busy_d;
    logic [BITWIDTH:0]   total;

    // Next-state: clear beats enable; the last enabled sample closes the window.
    always_comb begin
        state_d   = state_q;
        win_cnt_d = win_cnt_q;
        one_cnt_d = one_cnt_q;
        bin_d     = bin_q;
        sat_d     = sat_q;
        valid_d   = 1'b0;
        total     = one_cnt_q + {{BITWIDTH{1'b0}}, iUnary};
        if (iClr) begin
            win_cnt_d = '0;
            one_cnt_d = '0;
            state_d   = IDLE;
        end else if (iEn) begin
            if (win_cnt_q == WIN_LAST) begin
                bin_d     = (total == FULL) ? WIN_LAST : total[BITWIDTH-1:0];
                sat_d     = (total == FULL);
                valid_d   = 1'b1;
                win_cnt_d = '0;
                one_cnt_d = '0;
                state_d   = IDLE;
            end else begin
                win_cnt_d = win_cnt_q + WIN_INC;
                one_cnt_d = total;
                state_d   = ACCUM;
            end
        end
        busy_d = (state_d == ACCUM);
    end

    // State, counters and registered outputs; reset acts without a clock.
    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            state_q   <= IDLE;
            win_cnt_q <= '0;
            one_cnt_q <= '0;
            bin_q     <= '0;
            valid_q   <= 1'b0;
            sat_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            win_cnt_q <= win_cnt_d;
            one_cnt_q <= one_cnt_d;
            bin_q     <= bin_d;
            valid_q   <= valid_d;
            sat_q     <= sat_d;
            busy_q    <= busy_d;
        end
    end

    assign oBin   = bin_q;
    assign oValid = valid_q;
    assign oSat   = sat_q;
    assign oBusy  = busy_q;

endmodule

// File: tb/tb_unary_bin_decoder.sv
// tb/tb_unary_bin_decoder.sv - self-checking bench for unary_bin_decoder at BITWIDTH=4
module tb_unary_bin_decoder;

    localparam int BW = 4;

    logic          iClk;
    logic          iRstN;
    logic          iEn;
    logic          iClr;
    logic          iUnary;
    logic [BW-1:0] oBin;
    logic          oValid;
    logic          oSat;
    logic          oBusy;

    unary_bin_decoder #(.BITWIDTH(BW)) dut (
        .iClk   (iClk),
        .iRstN  (iRstN),
        .iEn    (iEn),
        .iClr   (iClr),
        .iUnary (iUnary),
        .oBin   (oBin),
        .oValid (oValid),
        .oSat   (oSat),
        .oBusy  (oBusy)
    );

    typedef struct {
        logic [15:0]   pattern;
        logic [BW-1:0] bin;
        logic          sat;
    } vec_t;

    typedef struct {
        logic [BW-1:0] bin;
        logic          sat;
    } exp_t;

    vec_t vecs[6];
    exp_t exp_q[$];
    int   pass_cnt   = 0;
    int   total_cnt  = 0;
    int   pushed     = 0;
    int   valid_seen = 0;

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    task automatic chk(input string name, input int got, input int exp);
        total_cnt++;
        if (got == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", name, got, exp);
    endtask

    // Scoreboard: every oValid pulse must match the oldest outstanding expectation.
    always @(negedge iClk) begin
        if (iRstN && oValid) begin
            valid_seen++;
            if (exp_q.size() == 0) begin
                chk("unexpected_valid", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("window_bin", int'(oBin), int'(e.bin));
                chk("window_sat", int'(oSat), int'(e.sat));
            end
        end
    end

    task automatic push_exp(input logic [BW-1:0] b, input logic s);
        exp_t e;
        e.bin = b;
        e.sat = s;
        exp_q.push_back(e);
        pushed++;
    endtask

    task automatic step(input logic en, input logic u, input logic clr);
        iEn    = en;
        iUnary = u;
        iClr   = clr;
        @(posedge iClk);
        #1;
    endtask

    // One full window with iEn held high; busy must rise after the first sample.
    task automatic run_window(input logic [15:0] pattern, input logic [BW-1:0] b, input logic s);
        for (int i = 0; i < 16; i++) begin
            chk("busy_in_window", int'(oBusy), (i != 0) ? 1 : 0);
            if (i == 15) push_exp(b, s);
            step(1'b1, pattern[i], 1'b0);
        end
        chk("valid_at_end", int'(oValid), 1);
        chk("busy_at_end", int'(oBusy), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{16'h0000, 4'd0,  1'b0};
        vecs[1] = '{16'h1249, 4'd5,  1'b0};
        vecs[2] = '{16'hFFFF, 4'd15, 1'b1};
        vecs[3] = '{16'h00FF, 4'd8,  1'b0};
        vecs[4] = '{16'hA5A5, 4'd8,  1'b0};
        vecs[5] = '{16'h0421, 4'd3,  1'b0};

        iRstN  = 1'b0;
        iEn    = 1'b0;
        iClr   = 1'b0;
        iUnary = 1'b0;
        #12;
        chk("reset_bin", int'(oBin), 0);
        chk("reset_valid", int'(oValid), 0);
        chk("reset_sat", int'(oSat), 0);
        chk("reset_busy", int'(oBusy), 0);
        #5 iRstN = 1'b1;
        @(posedge iClk);
        #1;

        // Back-to-back windows from the table, each followed by one idle cycle.
        for (int v = 0; v < 6; v++) begin
            run_window(vecs[v].pattern, vecs[v].bin, vecs[v].sat);
            step(1'b0, 1'b0, 1'b0);
            chk("valid_single_pulse", int'(oValid), 0);
        end

        // Value 10 with disabled gaps where iUnary toggles.
        for (int i = 0; i < 16; i++) begin
            repeat ($urandom_range(0, 3)) step(1'b0, 1'($urandom_range(0, 1)), 1'b0);
            if (i == 15) push_exp(4'd10, 1'b0);
            step(1'b1, (i < 10) ? 1'b1 : 1'b0, 1'b0);
        end
        chk("gap_valid_at_end", int'(oValid), 1);

        // Clear mid-window: previous result holds, partial window discarded.
        run_window(16'h0F00, 4'd4, 1'b0);
        for (int i = 0; i < 7; i++) step(1'b1, (i < 3) ? 1'b1 : 1'b0, 1'b0);
        chk("pre_clr_busy", int'(oBusy), 1);
        step(1'b1, 1'b1, 1'b1);
        chk("clr_bin_hold", int'(oBin), 4);
        chk("clr_valid", int'(oValid), 0);
        chk("clr_busy", int'(oBusy), 0);
        run_window(16'h01FF, 4'd9, 1'b0);

        // Clear on the last sample of a window suppresses the result.
        for (int i = 0; i < 15; i++) step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1);
        chk("clr_last_valid", int'(oValid), 0);
        chk("clr_last_busy", int'(oBusy), 0);
        chk("clr_last_bin", int'(oBin), 9);
        run_window(16'h8001, 4'd2, 1'b0);

        // Asynchronous reset between edges in the middle of a window.
        for (int i = 0; i < 9; i++) step(1'b1, 1'b1, 1'b0);
        #2 iRstN = 1'b0;
        #1;
        chk("async_bin", int'(oBin), 0);
        chk("async_valid", int'(oValid), 0);
        chk("async_sat", int'(oSat), 0);
        chk("async_busy", int'(oBusy), 0);
        #2 iRstN = 1'b1;
        run_window(16'h0421, 4'd3, 1'b0);

        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        chk("scoreboard_empty", exp_q.size(), 0);
        chk("valid_count", valid_seen, pushed);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
